// File: rtl/touch_filter_if.sv
// rtl/touch_filter_if.sv - raw reading strobe and filtered touch outputs between read driver, filter and clip stage
interface touch_filter_if;
    logic        raw_valid;
    logic [2:0]  raw_num;
    logic [31:0] raw_xy;
    logic [2:0]  tp_num;
    logic [31:0] tp1_xy;
    logic        touch_active;
    logic        press_pulse;
    logic        release_pulse;

    modport master (
        output raw_valid, raw_num, raw_xy,
        input  tp_num, tp1_xy, touch_active, press_pulse, release_pulse
    );

    modport slave (
        input  raw_valid, raw_num, raw_xy,
        output tp_num, tp1_xy, touch_active, press_pulse, release_pulse
    );
endinterface

// File: rtl/touch_filter.sv
// rtl/touch_filter.sv - press/release debounce and box-average of point-1 coordinates (optional TOUCH_JUMP_REJECT_EN)
module touch_filter #(
    parameter int          PRESS_CNT   = 3,
    parameter int          RELEASE_CNT = 3,
    parameter int          AVG_LOG2    = 2,
    parameter logic [15:0] JUMP_TH     = 16'd40
) (
    input  logic clk,
    input  logic rst_n,
    touch_filter_if.slave i_tf
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 16 + AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [7:0] P_CNT = 8'(PRESS_CNT);
    localparam logic [7:0] R_CNT = 8'(RELEASE_CNT);

    typedef enum logic [1:0] {S_IDLE, S_PRESS_WAIT, S_TOUCHED, S_RELEASE_WAIT} state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [2:0]         w_num;
    logic               w_touched;
    logic               w_push, w_seed, w_press, w_release;
    logic               w_reject, w_reseed, w_push_eff, w_seed_eff;
    logic [15:0]        w_x, w_y;
    logic [31:0]        r_win [DEPTH];
    logic [PTR_W-1:0]   r_ptr;
    logic [SUM_W-1:0]   r_sum_x, r_sum_y, w_sum_x_push, w_sum_y_push;
    logic [2:0]         r_tp_num;
    logic [31:0]        r_tp1_xy;
    logic               r_active, r_press, r_release;

    assign w_x       = i_tf.raw_xy[31:16];
    assign w_y       = i_tf.raw_xy[15:0];
    assign w_num     = (i_tf.raw_num > 3'd5) ? 3'd5 : i_tf.raw_num;
    assign w_touched = (i_tf.raw_num != 3'd0);
    assign w_cnt_inc = r_cnt + 8'd1;

    // Modular arithmetic: the true sum is never negative, so add-then-subtract is exact.
    assign w_sum_x_push = r_sum_x + SUM_W'(w_x) - SUM_W'(r_win[r_ptr][31:16]);
    assign w_sum_y_push = r_sum_y + SUM_W'(w_y) - SUM_W'(r_win[r_ptr][15:0]);

`ifdef TOUCH_JUMP_REJECT_EN
    logic        r_outlier;
    logic [15:0] w_dx, w_dy;
    logic        w_jump, w_tracking;

    assign w_dx       = (w_x >= r_tp1_xy[31:16]) ? (w_x - r_tp1_xy[31:16]) : (r_tp1_xy[31:16] - w_x);
    assign w_dy       = (w_y >= r_tp1_xy[15:0])  ? (w_y - r_tp1_xy[15:0])  : (r_tp1_xy[15:0] - w_y);
    assign w_jump     = (w_dx > JUMP_TH) || (w_dy > JUMP_TH);
    assign w_tracking = i_tf.raw_valid && w_touched &&
                        ((r_state == S_TOUCHED) || (r_state == S_RELEASE_WAIT));
    assign w_reject   = w_tracking && w_jump && !r_outlier;
    assign w_reseed   = w_tracking && w_jump && r_outlier;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_outlier <= 1'b0;
        else if (i_tf.raw_valid)
            r_outlier <= w_reject;
    end
`else
    logic [15:0] w_unused_th;
    assign w_unused_th = JUMP_TH;
    assign w_reject    = 1'b0;
    assign w_reseed    = 1'b0;
`endif

    assign w_push_eff = w_push && !w_reject && !w_reseed;
    assign w_seed_eff = w_seed || w_reseed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_seed      = 1'b0;
        w_press     = 1'b0;
        w_release   = 1'b0;
        if (i_tf.raw_valid) begin
            case (r_state)
                S_IDLE: if (w_touched) begin
                    if (P_CNT <= 8'd1) begin
                        w_state_nxt = S_TOUCHED;
                        w_seed      = 1'b1;
                        w_press     = 1'b1;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = S_PRESS_WAIT;
                        w_cnt_nxt   = 8'd1;
                    end
                end
                S_PRESS_WAIT: if (!w_touched) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (w_cnt_inc >= P_CNT) begin
                    w_state_nxt = S_TOUCHED;
                    w_seed      = 1'b1;
                    w_press     = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
                S_TOUCHED: if (w_touched) begin
                    w_push = 1'b1;
                end else if (R_CNT <= 8'd1) begin
                    w_state_nxt = S_IDLE;
                    w_release   = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = 8'd1;
                end
                default: if (w_touched) begin
                    w_state_nxt = S_TOUCHED;
                    w_push      = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else if (w_cnt_inc >= R_CNT) begin
                    w_state_nxt = S_IDLE;
                    w_release   = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_win[i] <= 32'd0;
            r_ptr     <= '0;
            r_sum_x   <= '0;
            r_sum_y   <= '0;
            r_tp_num  <= 3'd0;
            r_tp1_xy  <= 32'd0;
            r_active  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_press;
            r_release <= w_release;
            r_active  <= (w_state_nxt == S_TOUCHED) || (w_state_nxt == S_RELEASE_WAIT);
            if (w_seed_eff) begin
                for (int i = 0; i < DEPTH; i++) r_win[i] <= i_tf.raw_xy;
                r_ptr    <= '0;
                r_sum_x  <= SUM_W'(w_x) << AVG_LOG2;
                r_sum_y  <= SUM_W'(w_y) << AVG_LOG2;
                r_tp1_xy <= i_tf.raw_xy;
                r_tp_num <= w_num;
            end else if (w_push_eff) begin
                r_win[r_ptr] <= i_tf.raw_xy;
                r_ptr        <= r_ptr + 1'b1;
                r_sum_x      <= w_sum_x_push;
                r_sum_y      <= w_sum_y_push;
                r_tp1_xy     <= {w_sum_x_push[SUM_W-1:AVG_LOG2], w_sum_y_push[SUM_W-1:AVG_LOG2]};
                r_tp_num     <= w_num;
            end else if (w_release) begin
                r_tp_num <= 3'd0;
            end
        end
    end

    assign i_tf.tp_num        = r_tp_num;
    assign i_tf.tp1_xy        = r_tp1_xy;
    assign i_tf.touch_active  = r_active;
    assign i_tf.press_pulse   = r_press;
    assign i_tf.release_pulse = r_release;
endmodule

// File: tb/tb_touch_filter.sv
// tb/tb_touch_filter.sv - vector table plus scoreboard bench for touch_filter
module tb_touch_filter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    touch_filter_if tf();

    touch_filter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tf  (tf.slave)
    );

    typedef struct {
        logic [2:0]  num;
        logic [31:0] xy;
        logic [2:0]  e_num;
        logic [31:0] e_xy;
        logic        e_act;
        logic        e_press;
        logic        e_rel;
    } vec_t;

    typedef struct {
        logic [2:0]  num;
        logic [31:0] xy;
        logic        act;
        logic        press;
        logic        rel;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[21];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".tp_num"}, 32'(tf.tp_num), 32'(e.num));
        check({tag, ".tp1_xy"}, tf.tp1_xy, e.xy);
        check({tag, ".touch_active"}, 32'(tf.touch_active), 32'(e.act));
        check({tag, ".press_pulse"}, 32'(tf.press_pulse), 32'(e.press));
        check({tag, ".release_pulse"}, 32'(tf.release_pulse), 32'(e.rel));
    endtask

    // One accepted reading, then one idle cycle with garbage inputs that must be ignored.
    task automatic strobe(input string tag, input logic [2:0] num, input logic [31:0] xy,
                          input logic [2:0] e_num, input logic [31:0] e_xy,
                          input logic e_act, input logic e_press, input logic e_rel);
        exp_t e;
        exp_t got;
        e = '{num: e_num, xy: e_xy, act: e_act, press: e_press, rel: e_rel};
        @(negedge clk);
        tf.raw_valid = 1'b1;
        tf.raw_num   = num;
        tf.raw_xy    = xy;
        sb.push_back(e);
        @(negedge clk);
        tf.raw_valid = 1'b0;
        tf.raw_num   = 3'(($urandom_range(0, 1) == 0) ? 0 : 1);
        tf.raw_xy    = $urandom;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check_outputs(tag, got);
            @(negedge clk);
            got.press = 1'b0;
            got.rel   = 1'b0;
            check_outputs({tag, ".hold"}, got);
        end
    endtask

    initial begin
        exp_t zero;
        zero = '{num: 3'd0, xy: 32'd0, act: 1'b0, press: 1'b0, rel: 1'b0};
        tf.raw_valid = 1'b0;
        tf.raw_num   = 3'd0;
        tf.raw_xy    = 32'd0;

        vecs[0]  = '{3'd1, 32'h019000F0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 32'h019000F0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 32'h019000F0, 3'd1, 32'h019000F0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'd1, 32'h019400F0, 3'd1, 32'h019100F0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'd1, 32'h019800F0, 3'd1, 32'h019300F0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'd1, 32'h019C00F0, 3'd1, 32'h019600F0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'd7, 32'h01A000F0, 3'd5, 32'h019A00F0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'd0, 32'h00000000, 3'd5, 32'h019A00F0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'd0, 32'h00000000, 3'd5, 32'h019A00F0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd1, 32'h019A00F0, 3'd1, 32'h019B00F0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd0, 32'h00000000, 3'd1, 32'h019B00F0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'd0, 32'h00000000, 3'd1, 32'h019B00F0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{3'd0, 32'h00000000, 3'd0, 32'h019B00F0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'd1, 32'h12345678, 3'd0, 32'h019B00F0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'd1, 32'h12345678, 3'd0, 32'h019B00F0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'd0, 32'h00000000, 3'd0, 32'h019B00F0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'd2, 32'h00100020, 3'd0, 32'h019B00F0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{3'd2, 32'h00100020, 3'd0, 32'h019B00F0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{3'd2, 32'h00100020, 3'd2, 32'h00100020, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{3'd3, 32'h00140024, 3'd3, 32'h00110021, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{3'd0, 32'h00000000, 3'd3, 32'h00110021, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check_outputs("reset", zero);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++)
            strobe($sformatf("vec%0d", i), vecs[i].num, vecs[i].xy,
                   vecs[i].e_num, vecs[i].e_xy, vecs[i].e_act, vecs[i].e_press, vecs[i].e_rel);

        // Now in RELEASE_WAIT: asynchronous reset must clear outputs without a clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs("async_rst", zero);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        strobe("post_rst0", 3'd1, 32'h00050006, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        strobe("post_rst1", 3'd1, 32'h00050006, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        strobe("post_rst2", 3'd1, 32'h00050006, 3'd1, 32'h00050006, 1'b1, 1'b1, 1'b0);

`ifdef TOUCH_JUMP_REJECT_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        strobe("jr_p0", 3'd1, 32'h019000F0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        strobe("jr_p1", 3'd1, 32'h019000F0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        strobe("jr_p2", 3'd1, 32'h019000F0, 3'd1, 32'h019000F0, 1'b1, 1'b1, 1'b0);
        strobe("jr_out1", 3'd2, 32'h025800F0, 3'd1, 32'h019000F0, 1'b1, 1'b0, 1'b0);
        strobe("jr_out2", 3'd2, 32'h025800F0, 3'd2, 32'h025800F0, 1'b1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
